// File: rtl/commit_bus_arbiter.sv
// commit_bus_arbiter
//   Round-robin arbiter that shares the single commit bus between NUM_RS
//   reservation stations. At most one station is granted per cycle; the
//   winner gets a one-cycle grant pulse, and its packet is registered onto
//   the shared commit bus. The register file and all stations snoop the bus.
//
// Ports
//   Clock         in   rising-edge clock
//   Reset         in   asynchronous, active-low reset
//   iRequest      in   [NUM_RS]           commit request, bit k = station k
//   iCommitData   in   [NUM_RS*PACKET_W]  station k packet at [k*PACKET_W +: PACKET_W]
//   iStall        in   freeze the bus; no new grant is issued
//   oGrant        out  [NUM_RS]  registered one-hot (or zero) grant pulse
//   oCommitBus    out  [PACKET_W] registered winning packet, zero when idle
//   oCommitValid  out  oCommitBus carries a packet this cycle
//   oGrantIdx     out  [IDX_W]   index of the last winner (holds when idle)
//   oBusy         out  OR of the effective (self-masked) requests

`ifndef COMMIT_PACKET_SIZE
`define COMMIT_PACKET_SIZE 32
`endif

module commit_bus_arbiter #(
  parameter int NUM_RS   = 4,
  parameter int PACKET_W = `COMMIT_PACKET_SIZE,
  parameter int IDX_W    = 2
) (
  input  logic                       Clock,
  input  logic                       Reset,
  input  logic [NUM_RS-1:0]          iRequest,
  input  logic [NUM_RS*PACKET_W-1:0] iCommitData,
  input  logic                       iStall,
  output logic [NUM_RS-1:0]          oGrant,
  output logic [PACKET_W-1:0]        oCommitBus,
  output logic                       oCommitValid,
  output logic [IDX_W-1:0]           oGrantIdx,
  output logic                       oBusy
);

  logic [IDX_W-1:0]    ptr;
  logic [NUM_RS-1:0]   effReq_p0;
  logic                hiValid_p0;
  logic [IDX_W-1:0]    hiIdx_p0;
  logic [IDX_W-1:0]    loIdx_p0;
  logic [IDX_W-1:0]    winIdx_p0;
  logic                vld_p0;
  logic [NUM_RS-1:0]   grantNext_p0;
  logic [PACKET_W-1:0] winPacket_p0;

  // Stage p0: combinational arbitration on the current request vector.
  // The station granted this cycle may still hold its request while it
  // retires, so it is masked out to avoid a double grant.
  assign effReq_p0 = iRequest & ~oGrant;
  assign oBusy     = |effReq_p0;
  assign vld_p0    = ~iStall & (|effReq_p0);

  // Round-robin search split in two: the lowest set bit at or above ptr
  // wins; if there is none, the search wraps to the lowest set bit overall.
  // Scanning downward leaves the lowest matching index in each result.
  always_comb begin
    hiValid_p0 = 1'b0;
    hiIdx_p0   = '0;
    loIdx_p0   = '0;
    for (int k = NUM_RS - 1; k >= 0; k--) begin
      if (effReq_p0[k]) begin
        loIdx_p0 = IDX_W'(k);
        if (IDX_W'(k) >= ptr) begin
          hiValid_p0 = 1'b1;
          hiIdx_p0   = IDX_W'(k);
        end
      end
    end
  end

  assign winIdx_p0 = hiValid_p0 ? hiIdx_p0 : loIdx_p0;

  always_comb begin
    grantNext_p0 = '0;
    winPacket_p0 = '0;
    for (int k = 0; k < NUM_RS; k++) begin
      if (winIdx_p0 == IDX_W'(k)) begin
        grantNext_p0[k] = vld_p0;
        winPacket_p0    = iCommitData[k*PACKET_W +: PACKET_W];
      end
    end
  end

  // Stage p1: registered grant and commit bus. The bus is zeroed when idle
  // so snoopers never see a stale write-enable.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      ptr          <= '0;
      oGrant       <= '0;
      oCommitBus   <= '0;
      oCommitValid <= 1'b0;
      oGrantIdx    <= '0;
    end else if (vld_p0) begin
      oGrant       <= grantNext_p0;
      oCommitBus   <= winPacket_p0;
      oCommitValid <= 1'b1;
      oGrantIdx    <= winIdx_p0;
      ptr          <= (winIdx_p0 == IDX_W'(NUM_RS - 1)) ? '0 : winIdx_p0 + IDX_W'(1);
    end else begin
      oGrant       <= '0;
      oCommitBus   <= '0;
      oCommitValid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_commit_bus_arbiter.sv
module tb_commit_bus_arbiter;

  localparam int NUM_RS   = 4;
  localparam int PACKET_W = 16;
  localparam int IDX_W    = 2;

  logic                       Clock;
  logic                       Reset;
  logic [NUM_RS-1:0]          iRequest;
  logic [NUM_RS*PACKET_W-1:0] iCommitData;
  logic                       iStall;
  logic [NUM_RS-1:0]          oGrant;
  logic [PACKET_W-1:0]        oCommitBus;
  logic                       oCommitValid;
  logic [IDX_W-1:0]           oGrantIdx;
  logic                       oBusy;

  int checks = 0;
  int errors = 0;

  commit_bus_arbiter #(
    .NUM_RS(NUM_RS),
    .PACKET_W(PACKET_W),
    .IDX_W(IDX_W)
  ) dut (
    .Clock(Clock),
    .Reset(Reset),
    .iRequest(iRequest),
    .iCommitData(iCommitData),
    .iStall(iStall),
    .oGrant(oGrant),
    .oCommitBus(oCommitBus),
    .oCommitValid(oCommitValid),
    .oGrantIdx(oGrantIdx),
    .oBusy(oBusy)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Station k packet is 16'h1111*(k+1).
  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  // Assert reset with the given requests/stall, hold two edges, then release
  // away from the clock edge.
  task automatic doReset(input logic [3:0] req, input logic stall);
    Reset    = 1'b0;
    iRequest = req;
    iStall   = stall;
    repeat (2) @(posedge Clock);
    #1;
    Reset = 1'b1;
  endtask

  task automatic checkGrant(input string name, input logic [3:0] expGrant,
                            input logic [1:0] expIdx, input logic [15:0] expBus,
                            input logic expValid);
    checks++;
    if (oGrant !== expGrant) begin
      errors++;
      $display("FAIL %s grant: got %b want %b", name, oGrant, expGrant);
    end
    checks++;
    if (oGrantIdx !== expIdx) begin
      errors++;
      $display("FAIL %s idx: got %0d want %0d", name, oGrantIdx, expIdx);
    end
    checks++;
    if (oCommitBus !== expBus) begin
      errors++;
      $display("FAIL %s bus: got %h want %h", name, oCommitBus, expBus);
    end
    checks++;
    if (oCommitValid !== expValid) begin
      errors++;
      $display("FAIL %s valid: got %b want %b", name, oCommitValid, expValid);
    end
  endtask

  task automatic test_reset();
    Reset    = 1'b0;
    iRequest = 4'b1111;
    iStall   = 1'b0;
    repeat (3) @(posedge Clock);
    #1;
    checkGrant("reset_hold", 4'b0000, 2'd0, 16'h0000, 1'b0);
    checks++;
    if (oBusy !== 1'b1) begin
      errors++;
      $display("FAIL reset_busy: got %b want 1", oBusy);
    end
    Reset = 1'b1;
    step();
    checkGrant("reset_first", 4'b0001, 2'd0, 16'h1111, 1'b1);
    iRequest = 4'b0000;
    step();
  endtask

  task automatic test_rotation();
    logic [3:0] req;
    doReset(4'b1111, 1'b0);
    req = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      step();
      checkGrant($sformatf("rot%0d", k), 4'(1 << k), 2'(k),
                 16'(16'h1111 * (k + 1)), 1'b1);
      req[k]   = 1'b0;
      iRequest = req;
    end
    #1;
    checks++;
    if (oBusy !== 1'b0) begin
      errors++;
      $display("FAIL rot_busy: got %b want 0", oBusy);
    end
    step();
    checkGrant("rot_idle", 4'b0000, 2'd3, 16'h0000, 1'b0);
  endtask

  task automatic test_wraparound();
    doReset(4'b0100, 1'b0);
    step();
    checkGrant("wrap_s2", 4'b0100, 2'd2, 16'h3333, 1'b1);
    iRequest = 4'b0011;
    step();
    checkGrant("wrap_s0", 4'b0001, 2'd0, 16'h1111, 1'b1);
    iRequest = 4'b0010;
    step();
    checkGrant("wrap_s1", 4'b0010, 2'd1, 16'h2222, 1'b1);
    iRequest = 4'b0000;
    step();
  endtask

  task automatic test_self_mask();
    doReset(4'b0000, 1'b0);
    iRequest = 4'b0100;
    step();
    checkGrant("mask_grant", 4'b0100, 2'd2, 16'h3333, 1'b1);
    #1;
    checks++;
    if (oBusy !== 1'b0) begin
      errors++;
      $display("FAIL mask_busy: got %b want 0", oBusy);
    end
    step();
    checkGrant("mask_idle", 4'b0000, 2'd2, 16'h0000, 1'b0);
    iRequest = 4'b0000;
    step();
    checkGrant("mask_idle2", 4'b0000, 2'd2, 16'h0000, 1'b0);
  endtask

  task automatic test_stall();
    doReset(4'b0110, 1'b1);
    for (int c = 0; c < 3; c++) begin
      step();
      checkGrant($sformatf("stall%0d", c), 4'b0000, 2'd0, 16'h0000, 1'b0);
    end
    checks++;
    if (oBusy !== 1'b1) begin
      errors++;
      $display("FAIL stall_busy: got %b want 1", oBusy);
    end
    iStall = 1'b0;
    step();
    checkGrant("stall_rel_s1", 4'b0010, 2'd1, 16'h2222, 1'b1);
    iRequest = 4'b0100;
    step();
    checkGrant("stall_rel_s2", 4'b0100, 2'd2, 16'h3333, 1'b1);
    iRequest = 4'b0000;
    step();
  endtask

  task automatic test_mid_reset();
    doReset(4'b0110, 1'b0);
    step();
    checkGrant("mid_pre", 4'b0010, 2'd1, 16'h2222, 1'b1);
    Reset = 1'b0;
    #1;
    checkGrant("mid_async", 4'b0000, 2'd0, 16'h0000, 1'b0);
    repeat (2) @(posedge Clock);
    #1;
    Reset = 1'b1;
    step();
    checkGrant("mid_regrant_s1", 4'b0010, 2'd1, 16'h2222, 1'b1);
    iRequest = 4'b0100;
    step();
    checkGrant("mid_then_s2", 4'b0100, 2'd2, 16'h3333, 1'b1);
    iRequest = 4'b0000;
    step();
  endtask

  initial begin
    Reset       = 1'b0;
    iRequest    = '0;
    iStall      = 1'b0;
    iCommitData = 64'h4444_3333_2222_1111;
    test_reset();
    test_rotation();
    test_wraparound();
    test_self_mask();
    test_stall();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
